// File: rtl/regfile_mp.sv
// Multi-port integer register file with prioritised writes, optional bypass,
// optional hardwired x0 and a one-entry-per-cycle sweep-clear engine.
module regfile_mp #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int NRD      = 2,
    parameter int NWR      = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            clr_req,
    output logic                            busy,
    input  logic [NRD*$clog2(NREGS)-1:0]    rd_addr,
    output logic [NRD*XLEN-1:0]             rd_data,
    input  logic [NWR-1:0]                  wr_en,
    input  logic [NWR*$clog2(NREGS)-1:0]    wr_addr,
    input  logic [NWR*XLEN-1:0]             wr_data
);

    localparam int AW = $clog2(NREGS);

    typedef enum logic {
        S_IDLE,
        S_CLEAR
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [AW-1:0]   r_cnt;
    logic [XLEN-1:0] r_regs [NREGS];

    logic            w_idle;
    logic            w_last;
    logic [AW-1:0]   w_waddr [NWR];
    logic [XLEN-1:0] w_wdata [NWR];
    logic [NWR-1:0]  w_wsup;
    logic [AW-1:0]   w_raddr [NRD];
    logic [XLEN-1:0] w_rval  [NRD];

    assign w_idle = (r_state == S_IDLE);
    assign w_last = (r_cnt == AW'(NREGS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (clr_req) w_next = S_CLEAR;
            S_CLEAR: if (w_last) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == S_CLEAR);
    end

    // Counter rests at 0 in IDLE so the sweep always starts at entry 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_idle) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + AW'(1);
        end
    end

    always_comb begin
        for (int j = 0; j < NWR; j++) begin
            w_waddr[j] = wr_addr[j*AW +: AW];
            w_wdata[j] = wr_data[j*XLEN +: XLEN];
            w_wsup[j]  = (ZERO_REG != 0) && (w_waddr[j] == '0);
        end
    end

    // Ascending port loop: the last assignment, i.e. the highest port, wins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NREGS; k++) begin
                r_regs[k] <= '0;
            end
        end else if (!w_idle) begin
            r_regs[r_cnt] <= '0;
        end else begin
            for (int j = 0; j < NWR; j++) begin
                if (wr_en[j] && !w_wsup[j]) begin
                    r_regs[w_waddr[j]] <= w_wdata[j];
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NRD; i++) begin
            w_raddr[i] = rd_addr[i*AW +: AW];
            w_rval[i]  = r_regs[w_raddr[i]];
            if ((BYPASS != 0) && w_idle) begin
                for (int j = 0; j < NWR; j++) begin
                    if (wr_en[j] && !w_wsup[j] && (w_waddr[j] == w_raddr[i])) begin
                        w_rval[i] = w_wdata[j];
                    end
                end
            end
            if ((ZERO_REG != 0) && (w_raddr[i] == '0)) begin
                w_rval[i] = '0;
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NRD; i++) begin
            rd_data[i*XLEN +: XLEN] = rst ? '0 : w_rval[i];
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: default, no-bypass and wide-port
// instances, directed vectors plus randomized traffic against a model.
module tb_regfile_mp;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Instance A: defaults (32 regs, 2R/2W, x0 hardwired, bypass on)
    logic        a_clr = 0, a_busy;
    logic [9:0]  a_ra = '0;
    logic [63:0] a_rd;
    logic [1:0]  a_we = '0;
    logic [9:0]  a_wa = '0;
    logic [63:0] a_wd = '0;

    // Instance B: bypass off
    logic        b_clr = 0, b_busy;
    logic [9:0]  b_ra = '0;
    logic [63:0] b_rd;
    logic [1:0]  b_we = '0;
    logic [9:0]  b_wa = '0;
    logic [63:0] b_wd = '0;

    // Instance C: 16 regs, 4R/3W, no hardwired zero
    logic        c_clr = 0, c_busy;
    logic [15:0] c_ra = '0;
    logic [127:0] c_rd;
    logic [2:0]  c_we = '0;
    logic [11:0] c_wa = '0;
    logic [95:0] c_wd = '0;

    regfile_mp u_a (
        .clk(clk), .rst(rst), .clr_req(a_clr), .busy(a_busy),
        .rd_addr(a_ra), .rd_data(a_rd),
        .wr_en(a_we), .wr_addr(a_wa), .wr_data(a_wd)
    );

    regfile_mp #(.BYPASS(0)) u_b (
        .clk(clk), .rst(rst), .clr_req(b_clr), .busy(b_busy),
        .rd_addr(b_ra), .rd_data(b_rd),
        .wr_en(b_we), .wr_addr(b_wa), .wr_data(b_wd)
    );

    regfile_mp #(.NREGS(16), .NRD(4), .NWR(3), .ZERO_REG(0)) u_c (
        .clk(clk), .rst(rst), .clr_req(c_clr), .busy(c_busy),
        .rd_addr(c_ra), .rd_data(c_rd),
        .wr_en(c_we), .wr_addr(c_wa), .wr_data(c_wd)
    );

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Reference model for instance A: array contents plus sweep position
    logic [31:0] mdl [32];
    int mclr = -1;

    task automatic model_reset();
        for (int k = 0; k < 32; k++) mdl[k] = '0;
        mclr = -1;
    endtask

    function automatic logic [31:0] exp_rd(input int a);
        logic [31:0] r;
        if (a == 0) return 32'h0;
        r = mdl[a];
        if (mclr < 0) begin
            for (int j = 0; j < 2; j++)
                if (a_we[j] && int'(a_wa[j*5 +: 5]) == a) r = a_wd[j*32 +: 32];
        end
        return r;
    endfunction

    task automatic model_edge();
        if (mclr < 0) begin
            for (int j = 0; j < 2; j++)
                if (a_we[j] && a_wa[j*5 +: 5] != 5'd0)
                    mdl[a_wa[j*5 +: 5]] = a_wd[j*32 +: 32];
            if (a_clr) mclr = 0;
        end else begin
            mdl[mclr] = '0;
            mclr++;
            if (mclr == 32) mclr = -1;
        end
    endtask

    task automatic cyc();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [1:0]  we;
        logic [4:0]  wa0, wa1;
        logic [31:0] wd0, wd1;
        logic [4:0]  ra0, ra1;
        logic [31:0] e0, e1;
    } vec_t;

    vec_t tbl [8];
    int nbusy;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{2'b01, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0};
        tbl[1] = '{2'b01, 5'd0, 5'd0, 32'h1234, 32'h0, 5'd0, 5'd5, 32'h0, 32'hDEADBEEF};
        tbl[2] = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd5, 32'h0, 32'hDEADBEEF};
        tbl[3] = '{2'b11, 5'd7, 5'd7, 32'hAAAA0000, 32'h5555FFFF, 5'd7, 5'd7, 32'h5555FFFF, 32'h5555FFFF};
        tbl[4] = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd7, 5'd5, 32'h5555FFFF, 32'hDEADBEEF};
        tbl[5] = '{2'b11, 5'd9, 5'd10, 32'h11, 32'h22, 5'd9, 5'd10, 32'h11, 32'h22};
        tbl[6] = '{2'b01, 5'd9, 5'd0, 32'h33, 32'h0, 5'd9, 5'd10, 32'h33, 32'h22};
        tbl[7] = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd9, 5'd10, 32'h33, 32'h22};
        model_reset();

        // Reset state, including a write that must not bypass during reset
        a_we = 2'b01; a_wa = 10'd5; a_wd = 64'hFF; a_ra = 10'd5;
        #12;
        chk("rst_a_busy", a_busy, 0);
        chk("rst_a_rd", a_rd, 0);
        chk("rst_b_busy", b_busy, 0);
        chk("rst_c_busy", c_busy, 0);
        chk("rst_c_rd", c_rd[63:0], 0);
        #1 rst = 1'b0;
        a_we = '0; a_wd = '0; a_ra = '0;
        @(posedge clk); #1;

        for (int v = 0; v < 8; v++) begin
            a_we = tbl[v].we;
            a_wa = {tbl[v].wa1, tbl[v].wa0};
            a_wd = {tbl[v].wd1, tbl[v].wd0};
            a_ra = {tbl[v].ra1, tbl[v].ra0};
            #2;
            chk("vec_rd0", a_rd[31:0], tbl[v].e0);
            chk("vec_rd1", a_rd[63:32], tbl[v].e1);
            chk("vec_busy", a_busy, 0);
            cyc();
        end
        a_we = '0;

        // Sweep clear: fill x1..x31 with their index
        for (int i = 1; i < 32; i += 2) begin
            a_we = (i == 31) ? 2'b01 : 2'b11;
            a_wa = {5'(i + 1), 5'(i)};
            a_wd = {32'(i + 1), 32'(i)};
            cyc();
        end
        a_we = '0;
        a_clr = 1'b1;
        #2 chk("clr_busy_pre", a_busy, 0);
        cyc();
        a_clr = 1'b0;
        nbusy = 0;
        for (int k = 0; k < 64; k++) begin
            a_we = '0;
            a_ra = '0;
            if (k == 3) begin
                a_we = 2'b01; a_wa = 10'd1; a_wd = 64'hFF; a_ra = 10'd1;
            end
            if (k == 4) a_ra = 10'd1;
            if (k == 10) a_ra = {5'd20, 5'd9};
            if (k == 32) begin
                a_we = 2'b01; a_wa = 10'd12; a_wd = 64'hABC; a_ra = {5'd12, 5'd0};
            end
            #2;
            if (!a_busy) break;
            nbusy++;
            if (k == 3) chk("clr_wr_nobyp", a_rd[31:0], 0);
            if (k == 4) chk("clr_wr_drop", a_rd[31:0], 0);
            if (k == 10) begin
                chk("clr_mid_x9", a_rd[31:0], 0);
                chk("clr_mid_x20", a_rd[63:32], 20);
            end
            cyc();
        end
        chk("clr_len32", nbusy, 32);
        chk("post_clr_byp", a_rd[63:32], 32'hABC);
        cyc();
        a_we = '0;
        for (int a = 0; a < 32; a += 2) begin
            a_ra = {5'(a + 1), 5'(a)};
            #2;
            chk("post_clr_rd0", a_rd[31:0], (a == 12) ? 32'hABC : 32'h0);
            chk("post_clr_rd1", a_rd[63:32], 0);
            cyc();
        end

        // Asynchronous reset in the middle of a sweep
        a_we = 2'b01; a_wa = 10'd20; a_wd = 64'h77;
        cyc();
        a_we = '0;
        a_clr = 1'b1;
        cyc();
        a_clr = 1'b0;
        repeat (5) cyc();
        a_ra = {5'd0, 5'd20};
        #1 chk("mid_x20_live", a_rd[31:0], 32'h77);
        #1 rst = 1'b1;
        #1;
        chk("rst_mid_busy", a_busy, 0);
        chk("rst_mid_x20", a_rd[31:0], 0);
        model_reset();
        #1 rst = 1'b0;
        a_we = 2'b01; a_wa = 10'd20; a_wd = 64'h99;
        #2 chk("rst_rel_byp", a_rd[31:0], 32'h99);
        cyc();
        a_we = '0;
        #2 chk("rst_rel_wr", a_rd[31:0], 32'h99);
        a_clr = 1'b1;
        cyc();
        a_clr = 1'b0;
        #2 chk("clr2_busy", a_busy, 1);
        for (int k = 0; k < 64 && a_busy; k++) cyc();
        chk("clr2_done", a_busy, 0);

        // Bypass disabled
        b_we = 2'b01; b_wa = 10'd3; b_wd = 64'h22;
        cyc();
        b_wd = 64'h11; b_ra = 10'd3;
        #2 chk("nobyp_old", b_rd[31:0], 32'h22);
        cyc();
        b_we = '0;
        #2 chk("nobyp_new", b_rd[31:0], 32'h11);

        // Wide-port instance
        c_we = 3'b111;
        c_wa = {4'd15, 4'd5, 4'd0};
        c_wd = {32'hF5, 32'h55, 32'hC0};
        cyc();
        c_we = '0;
        c_ra = {4'd1, 4'd15, 4'd5, 4'd0};
        #2;
        chk("c_x0", c_rd[31:0], 32'hC0);
        chk("c_x5", c_rd[63:32], 32'h55);
        chk("c_x15", c_rd[95:64], 32'hF5);
        chk("c_x1", c_rd[127:96], 0);
        c_we = 3'b111;
        c_wa = {4'd9, 4'd9, 4'd9};
        c_wd = {32'h3, 32'h2, 32'h1};
        c_ra = {4'd0, 4'd0, 4'd0, 4'd9};
        #1 chk("c_conf_byp", c_rd[31:0], 32'h3);
        cyc();
        c_we = '0;
        #2 chk("c_conf_wr", c_rd[31:0], 32'h3);
        c_clr = 1'b1;
        cyc();
        c_clr = 1'b0;
        nbusy = 0;
        for (int k = 0; k < 64; k++) begin
            #2;
            if (!c_busy) break;
            nbusy++;
            cyc();
        end
        chk("c_clr_len16", nbusy, 16);
        c_ra = {4'd9, 4'd15, 4'd5, 4'd0};
        #1;
        chk("c_clr_x0", c_rd[31:0], 0);
        chk("c_clr_x9", c_rd[127:96], 0);

        // Randomized traffic on instance A against the model
        for (int n = 0; n < 400; n++) begin
            a_we = 2'($urandom);
            a_wa = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            a_wd = {$urandom, $urandom};
            a_ra = (n % 3 == 0) ? 10'($urandom) :
                   {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            a_clr = ($urandom_range(0, 39) == 0);
            #2;
            for (int p = 0; p < 2; p++)
                chk("rnd_rd", a_rd[p*32 +: 32], exp_rd(int'(a_ra[p*5 +: 5])));
            chk("rnd_busy", a_busy, mclr >= 0);
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file for the RISC-V core; the next-generation replacement for the single-write, two-read register file. It provides NRD combinational read ports and NWR clocked write ports with fixed write-port priority, optional write-to-read bypass, an optional hardwired zero register, and a sequential sweep-clear engine. The engine zeroes the array one entry per cycle without asserting rst. It sits between the decode and writeback stages.

## Interface
- XLEN, 32: register data width in bits.
- NREGS, 32: number of registers, ≥2, power of two. AW = $clog2(NREGS).
- NRD, 2: number of read ports, ≥1.
- NWR, 2: number of write ports, ≥1.
- ZERO_REG, 1: 1 = register 0 always reads 0 and ignores writes.
- BYPASS, 1: 1 = a read returns the data being written to the same address in the same cycle.

- clk  in  1  clock, posedge-active for all state.
- rst  in  1  reset, asynchronous, active-high.
- clr_req  in  1  request a sweep clear; sampled at posedge.
- busy  out  1  high while the sweep clear runs.
- rd_addr  in  NRD*AW  read addresses; port i = bits [i*AW +: AW].
- rd_data  out  NRD*XLEN  read data; port i = bits [i*XLEN +: XLEN].
- wr_en  in  NWR  per-port write enable.
- wr_addr  in  NWR*AW  write addresses, packed as for rd_addr.
- wr_data  in  NWR*XLEN  write data, packed as for rd_data.

## Operation
- **Reset:** rst=1 asynchronously zeroes every register, the state register (to IDLE), and the clear counter. While reset is held, busy=0 and every rd_data=0.
- **States:** IDLE and CLEAR.
  - IDLE → CLEAR at a posedge with clr_req=1. The counter loads 0.
  - CLEAR: each posedge zeroes reg[cnt] and then cnt++.
  - CLEAR → IDLE at the posedge that clears reg[NREGS-1].
  - clr_req in CLEAR is ignored and not queued.
- **Writes, IDLE only:** at posedge, each port j with wr_en[j]=1 writes wr_data[j] to reg[wr_addr[j]].
  - If several ports target the same address, the highest-numbered port wins.
  - With ZERO_REG=1, writes to address 0 are dropped.
  - Writes presented in CLEAR are dropped silently.
- **Reads:** purely combinational from rd_addr.
  - ZERO_REG=1 and addr=0 → 0.
  - Otherwise, if BYPASS=1, state=IDLE, and some enabled write port targets the same address (and that address is not zero-suppressed), return that port's data. Among several matching ports, the highest-numbered port's data is returned.
  - Otherwise return the stored value.
  - Bypass is disabled in CLEAR. Reads in CLEAR return the current array contents: entries below cnt are already 0.
- **Arithmetic:** cnt is AW bits wide; termination compares cnt against NREGS-1, so there is no wrap-around past the last entry.

## Timing
- Read latency: 0 cycles (combinational).
- Write latency: 1 edge, data visible via the array after the posedge. With BYPASS=1 it is visible in the same cycle.
- **clr_req and writes in the same IDLE cycle:** the writes commit at that edge, then get cleared by the sweep.
- busy rises one cycle after clr_req is sampled and stays high for exactly NREGS cycles.
- The first IDLE cycle after busy falls accepts writes and bypass normally.
- rst asserted mid-CLEAR aborts the sweep immediately: array=0, IDLE, busy=0. Deassertion takes effect on the next posedge.
- **Reset values of outputs:** busy=0, rd_data=0 on all ports.

## Test plan
- **Reset then write/read:** release rst; write 0xDEADBEEF to x5 via port 0; next cycle read x5 on port 1 → 0xDEADBEEF. Read x0 → 0 after writing 0x1234 to x0.
- **Write conflict:** in one cycle, port0 writes 0xAAAA0000 to x7 and port1 writes 0x5555FFFF to x7. Next cycle x7 → 0x5555FFFF. With BYPASS=1, the same-cycle read of x7 also → 0x5555FFFF.
- **Bypass off:** BYPASS=0; write 0x11 to x3 while reading x3 holding old value 0x22 → read 0x22; next cycle → 0x11.
- **Sweep clear:** fill x1..x31 with index values; pulse clr_req.
  - busy high for 32 cycles.
  - Mid-sweep at cnt=10: x9 → 0, x20 → 20.
  - A write of 0xFF to x1 during busy is dropped.
  - After busy falls, all reads → 0.
- **Reset mid-clear:** assert rst asynchronously at cnt=5 (not on a clock edge) → busy=0 and all reads 0 immediately. After release, a write works on the next edge and a second clr_req is accepted.
- **Parameter sweep:** NREGS=16, NRD=4, NWR=3, ZERO_REG=0.
  - A write to x0 sticks.
  - Four simultaneous reads of distinct registers return the correct values.
  - busy high for 16 cycles per clear.
